rv32_mem_dump_engine: RTL and testbench

- Synthesisable, parametrised memory-dump engine for the rv32 single-cycle platform.
- Walks a byte range of data memory through a read-only side port and streams each byte out on a valid/ready interface.
- Flags end-of-line every BYTES_PER_LINE bytes and flags the final byte.
- Used by both benches and on-chip debug logic to read out data memory, in place of hierarchical peeks.

---
 rtl/rv32_mem_dump_engine.sv | 157 +++++++++++++++
 tb/tb_rv32_mem_dump_engine.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rv32_mem_dump_engine.sv
// Memory-dump engine: walks a byte range of data memory through a read-only
// side port and streams each byte out on a valid/ready interface, marking
// end-of-line and the final byte.
//
// state  | meaning
// -------+-----------------------------------------------------------
// S_IDLE | waiting for start; abort ignored
// S_REQ  | read strobe for byte idx at base+idx
// S_WAIT | read data returns; capture it into the output register
// S_OUT  | byte presented, waiting for handshake
// S_FIN  | one-cycle done pulse, then back to idle
module rv32_mem_dump_engine #(
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned LEN_WIDTH      = 16,
  parameter int unsigned BYTES_PER_LINE = 16
) (
  input  logic                  clk_i,
  input  logic                  reset_n_i,
  input  logic                  start_i,
  input  logic                  abort_i,
  input  logic [ADDR_WIDTH-1:0] base_addr_i,
  input  logic [LEN_WIDTH-1:0]  length_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  mem_rd_en_o,
  output logic [ADDR_WIDTH-1:0] mem_rd_addr_o,
  input  logic [7:0]            mem_rd_data_i,
  output logic                  out_valid_o,
  input  logic                  out_ready_i,
  output logic [7:0]            out_data_o,
  output logic                  out_eol_o,
  output logic                  out_last_o
);

  // Position within the current line is tracked by its own wrapping counter,
  // so no modulo by BYTES_PER_LINE is needed.
  localparam int unsigned LINE_W = (BYTES_PER_LINE > 1) ? $clog2(BYTES_PER_LINE) : 1;
  localparam logic [LINE_W-1:0] LINE_MAX = LINE_W'(BYTES_PER_LINE - 1);
  localparam logic [LINE_W-1:0] LINE_ONE = LINE_W'(1);
  localparam logic [LEN_WIDTH-1:0] LEN_ONE = LEN_WIDTH'(1);

  typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT, S_OUT, S_FIN} state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] base_q, base_d;
  logic [LEN_WIDTH-1:0]  len_q, len_d;
  logic [LEN_WIDTH-1:0]  idx_q, idx_d;
  logic [LINE_W-1:0]     line_q, line_d;
  logic                  valid_q, valid_d;
  logic [7:0]            data_q, data_d;
  logic                  eol_q, eol_d;
  logic                  last_q, last_d;
  logic                  is_last;
  logic                  line_end;

  assign is_last  = (idx_q == len_q - LEN_ONE);
  assign line_end = (line_q == LINE_MAX);

  // State and datapath registers.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q <= S_IDLE;
      base_q  <= '0;
      len_q   <= '0;
      idx_q   <= '0;
      line_q  <= '0;
      valid_q <= 1'b0;
      data_q  <= '0;
      eol_q   <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      base_q  <= base_d;
      len_q   <= len_d;
      idx_q   <= idx_d;
      line_q  <= line_d;
      valid_q <= valid_d;
      data_q  <= data_d;
      eol_q   <= eol_d;
      last_q  <= last_d;
    end
  end

  // Next-state logic; abort wins over a simultaneous handshake.
  always_comb begin
    state_d = state_q;
    base_d  = base_q;
    len_d   = len_q;
    idx_d   = idx_q;
    line_d  = line_q;
    valid_d = valid_q;
    data_d  = data_q;
    eol_d   = eol_q;
    last_d  = last_q;
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          if (length_i != '0) begin
            base_d  = base_addr_i;
            len_d   = length_i;
            idx_d   = '0;
            line_d  = '0;
            state_d = S_REQ;
          end else begin
            state_d = S_FIN;
          end
        end
      end
      S_REQ: begin
        state_d = abort_i ? S_IDLE : S_WAIT;
      end
      S_WAIT: begin
        if (abort_i) begin
          state_d = S_IDLE;
        end else begin
          data_d  = mem_rd_data_i;
          valid_d = 1'b1;
          eol_d   = line_end || is_last;
          last_d  = is_last;
          state_d = S_OUT;
        end
      end
      S_OUT: begin
        if (abort_i) begin
          valid_d = 1'b0;
          state_d = S_IDLE;
        end else if (out_ready_i) begin
          valid_d = 1'b0;
          if (last_q) begin
            state_d = S_FIN;
          end else begin
            idx_d   = idx_q + LEN_ONE;
            line_d  = line_end ? '0 : line_q + LINE_ONE;
            state_d = S_REQ;
          end
        end
      end
      S_FIN: begin
        state_d = S_IDLE;
      end
      default: begin
        valid_d = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  assign busy_o        = (state_q == S_REQ) || (state_q == S_WAIT) || (state_q == S_OUT);
  assign done_o        = (state_q == S_FIN);
  assign mem_rd_en_o   = (state_q == S_REQ);
  assign mem_rd_addr_o = (state_q == S_REQ) ? base_q + ADDR_WIDTH'(idx_q) : '0;
  assign out_valid_o   = valid_q;
  assign out_data_o    = data_q;
  assign out_eol_o     = eol_q;
  assign out_last_o    = last_q;

endmodule

// File: tb/tb_rv32_mem_dump_engine.sv
// Bench for rv32_mem_dump_engine: two instances (16- and 3-byte lines) share
// stimulus; a reference of expected read addresses and beats is built from
// base/length per transfer and checked by a negedge monitor.
module tb_rv32_mem_dump_engine;

  logic        clk;
  logic        reset_n;
  logic        start;
  logic        abort;
  logic [31:0] base;
  logic [15:0] length;
  logic        ready;
  int          sel;

  logic        busy_w  [2];
  logic        done_w  [2];
  logic        rd_en_w [2];
  logic [31:0] addr_w  [2];
  logic [7:0]  rd_data [2];
  logic        valid_w [2];
  logic [7:0]  data_w  [2];
  logic        eol_w   [2];
  logic        last_w  [2];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int rmode = 0;
  int pat_ctr = 0;
  logic [7:0] salt = 8'h00;
  bit mon_en = 1'b0;

  logic [31:0] exp_addr [$];
  logic [7:0]  exp_data [$];
  logic        exp_eol  [$];
  logic        exp_last [$];
  int beats;
  int done_cnt;
  int last_hs_cyc;
  int done_cyc;
  bit prev_stall;
  logic [7:0] h_data;
  logic h_eol;
  logic h_last;

  rv32_mem_dump_engine u_dut16 (
    .clk_i(clk), .reset_n_i(reset_n), .start_i(start && sel == 0), .abort_i(abort),
    .base_addr_i(base), .length_i(length), .busy_o(busy_w[0]), .done_o(done_w[0]),
    .mem_rd_en_o(rd_en_w[0]), .mem_rd_addr_o(addr_w[0]), .mem_rd_data_i(rd_data[0]),
    .out_valid_o(valid_w[0]), .out_ready_i(ready), .out_data_o(data_w[0]),
    .out_eol_o(eol_w[0]), .out_last_o(last_w[0])
  );

  rv32_mem_dump_engine #(.BYTES_PER_LINE(3)) u_dut3 (
    .clk_i(clk), .reset_n_i(reset_n), .start_i(start && sel == 1), .abort_i(abort),
    .base_addr_i(base), .length_i(length), .busy_o(busy_w[1]), .done_o(done_w[1]),
    .mem_rd_en_o(rd_en_w[1]), .mem_rd_addr_o(addr_w[1]), .mem_rd_data_i(rd_data[1]),
    .out_valid_o(valid_w[1]), .out_ready_i(ready), .out_data_o(data_w[1]),
    .out_eol_o(eol_w[1]), .out_last_o(last_w[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] mem_byte(input logic [31:0] a);
    return a[7:0] ^ a[23:16] ^ salt;
  endfunction

  // Synchronous memory: data valid one cycle after the read strobe.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rd_en_w[0]) rd_data[0] <= mem_byte(addr_w[0]);
    if (rd_en_w[1]) rd_data[1] <= mem_byte(addr_w[1]);
  end

  // Consumer ready pattern.
  always @(posedge clk) begin
    #1;
    case (rmode)
      0: ready = 1'b1;
      1: begin
        ready = (pat_ctr % 4 == 0) || (pat_ctr % 4 == 3);
        pat_ctr++;
      end
      default: ready = 1'($urandom_range(0, 1));
    endcase
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got 0x%08h want 0x%08h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Monitor: read addresses, beat contents, stall stability, done pulses.
  always @(negedge clk) begin
    if (mon_en && reset_n) begin
      if (rd_en_w[sel]) begin
        if (exp_addr.size() == 0) chk("rd_spurious", 32'(rd_en_w[sel]), 0);
        else chk("rd_addr", addr_w[sel], exp_addr.pop_front());
      end
      if (prev_stall) begin
        chk("stall_valid", 32'(valid_w[sel]), 1);
        chk("stall_data", 32'(data_w[sel]), 32'(h_data));
        chk("stall_eol", 32'(eol_w[sel]), 32'(h_eol));
        chk("stall_last", 32'(last_w[sel]), 32'(h_last));
      end
      prev_stall = 1'b0;
      if (valid_w[sel]) begin
        if (ready && !abort) begin
          if (exp_data.size() == 0) begin
            chk("beat_spurious", 32'(valid_w[sel]), 0);
          end else begin
            chk("beat_data", 32'(data_w[sel]), 32'(exp_data.pop_front()));
            chk("beat_eol", 32'(eol_w[sel]), 32'(exp_eol.pop_front()));
            chk("beat_last", 32'(last_w[sel]), 32'(exp_last.pop_front()));
          end
          beats++;
          last_hs_cyc = cyc;
        end else if (!ready && !abort) begin
          prev_stall = 1'b1;
          h_data = data_w[sel];
          h_eol  = eol_w[sel];
          h_last = last_w[sel];
        end
      end
      if (done_w[sel]) begin
        done_cnt++;
        done_cyc = cyc;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic build_exp(input int s, input logic [31:0] b, input int n);
    int bpl;
    logic [31:0] a;
    bpl = (s == 1) ? 3 : 16;
    exp_addr.delete(); exp_data.delete(); exp_eol.delete(); exp_last.delete();
    for (int i = 0; i < n; i++) begin
      a = b + 32'(i);
      exp_addr.push_back(a);
      exp_data.push_back(mem_byte(a));
      exp_eol.push_back(((i + 1) % bpl == 0) || (i == n - 1));
      exp_last.push_back(i == n - 1);
    end
    beats = 0;
    done_cnt = 0;
    prev_stall = 1'b0;
  endtask

  task automatic start_pulse(input logic [31:0] b, input int n);
    start = 1'b1;
    base = b;
    length = 16'(n);
    tick();
    start = 1'b0;
    base = $urandom;
    length = 16'($urandom);
  endtask

  task automatic run_xfer(input int s, input logic [31:0] b, input int n, input int rm, input bit poke);
    sel = s;
    rmode = rm;
    build_exp(s, b, n);
    start_pulse(b, n);
    if (n == 0) begin
      chk("zero_busy", 32'(busy_w[sel]), 0);
      chk("zero_done", 32'(done_w[sel]), 1);
    end else begin
      chk("busy_after_start", 32'(busy_w[sel]), 1);
      if (rm == 0) begin
        tick();
        chk("valid_early", 32'(valid_w[sel]), 0);
        tick();
        chk("first_valid", 32'(valid_w[sel]), 1);
      end
    end
    for (int k = 0; k < n * 40 + 20; k++) begin
      if (done_cnt != 0) break;
      if (poke && k == 5) begin
        start = 1'b1;
        base = $urandom;
        length = 16'($urandom);
      end else begin
        start = 1'b0;
      end
      tick();
    end
    start = 1'b0;
    chk("done_seen", 32'(done_cnt), 1);
    chk("beats", 32'(beats), 32'(n));
    chk("addr_left", 32'(exp_addr.size()), 0);
    chk("busy_end", 32'(busy_w[sel]), 0);
    if (n > 0) chk("done_latency", 32'((done_cyc > last_hs_cyc) && (done_cyc - last_hs_cyc <= 3)), 1);
    tick();
    tick();
    chk("done_once", 32'(done_cnt), 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "timeout");
  end

  initial begin
    reset_n = 1'b0; start = 1'b0; abort = 1'b0; base = '0; length = '0; ready = 1'b1; sel = 0;
    #12;
    for (int s = 0; s < 2; s++) begin
      chk("rst_outs", {busy_w[s], done_w[s], rd_en_w[s], valid_w[s], eol_w[s], last_w[s]}, 0);
      chk("rst_addr", addr_w[s], 0);
      chk("rst_data", 32'(data_w[s]), 0);
    end
    tick();
    reset_n = 1'b1;
    mon_en = 1'b1;
    tick();

    salt = 8'h00;
    run_xfer(0, 32'h0000_0400, 1024, 0, 1'b0);
    run_xfer(0, 32'h0000_2000, 4, 1, 1'b0);
    run_xfer(0, 32'h0000_0123, 0, 0, 1'b0);
    run_xfer(1, 32'h0000_0050, 5, 0, 1'b0);
    run_xfer(0, 32'hFFFF_FFFE, 4, 0, 1'b0);
    run_xfer(1, 32'h0000_8000, 9, 1, 1'b1);

    // Abort during the third beat's presentation with ready high.
    sel = 0; rmode = 0;
    salt = 8'h5A;
    build_exp(0, 32'h0000_3000, 5);
    start_pulse(32'h0000_3000, 5);
    for (int k = 0; k < 200; k++) begin
      if (beats == 2 && valid_w[0]) break;
      tick();
    end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_busy", 32'(busy_w[0]), 0);
    chk("abort_valid", 32'(valid_w[0]), 0);
    chk("abort_rd_en", 32'(rd_en_w[0]), 0);
    chk("abort_beats", 32'(beats), 2);
    chk("abort_no_done", 32'(done_cnt), 0);
    run_xfer(0, 32'h0000_0010, 2, 0, 1'b0);

    // Asynchronous reset while a read is returning.
    mon_en = 1'b0;
    sel = 0;
    salt = 8'hC3;
    start_pulse(32'h0000_0777, 4);
    tick();
    #2;
    reset_n = 1'b0;
    #1;
    chk("arst_outs", {busy_w[0], done_w[0], rd_en_w[0], valid_w[0], eol_w[0], last_w[0]}, 0);
    chk("arst_addr", addr_w[0], 0);
    chk("arst_data", 32'(data_w[0]), 0);
    tick();
    reset_n = 1'b1;
    tick();
    chk("arst_idle_busy", 32'(busy_w[0]), 0);
    chk("arst_idle_rd", 32'(rd_en_w[0]), 0);
    mon_en = 1'b1;
    run_xfer(0, 32'h0000_0900, 3, 0, 1'b0);

    for (int t = 0; t < 12; t++) begin
      int n;
      n = $urandom_range(1, 40);
      salt = 8'($urandom);
      run_xfer($urandom_range(0, 1), $urandom, n, 2, n >= 4);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
